// File: rtl/cp0_pkg.sv
// Shared CP0 register numbers, bit positions, write masks and reset values
// used by the register file and its timer.
package cp0_pkg;

   localparam logic [4:0] CP0_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_COUNT    = 5'd9;
   localparam logic [4:0] CP0_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_STATUS   = 5'd12;
   localparam logic [4:0] CP0_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_EPC      = 5'd14;

   localparam int unsigned IE_BIT  = 0;
   localparam int unsigned EXL_BIT = 1;
   localparam int unsigned IM_LSB  = 8;
   localparam int unsigned IP_LSB  = 8;
   localparam int unsigned TI_BIT  = 30;
   localparam int unsigned BD_BIT  = 31;
   localparam int unsigned BEV_BIT = 22;

   localparam logic [31:0] STATUS_WMASK   = 32'h0000_FF03;
   localparam logic [31:0] CAUSE_SWMASK   = 32'h0000_0300;
   localparam logic [31:0] STATUS_RST_DEF = 32'h0040_0000;
   localparam logic [31:0] REG_RST        = '0;

   // Writable Status bits come from d; everything else holds its reset value.
   function automatic logic [31:0] status_merge(input logic [31:0] d,
                                                input logic [31:0] rstv);
      return (d & STATUS_WMASK) | (rstv & ~STATUS_WMASK);
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: phase divider, free-running Count, Compare and the
// sticky timer interrupt.
module cp0_timer
   import cp0_pkg::*;
#(
   parameter int unsigned COUNT_DIV = 2
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_count_we,
   input  logic        i_compare_we,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_count,
   output logic [31:0] o_compare,
   output logic        o_timer_int
);

   localparam logic PHASE_LAST = (COUNT_DIV == 2) ? 1'b1 : 1'b0;

   logic        r_phase;
   logic [31:0] r_count;
   logic [31:0] r_compare;
   logic        r_timer_int;
   logic        w_tick;
   logic [31:0] w_count_inc;

   assign w_tick      = (r_phase == PHASE_LAST);
   assign w_count_inc = r_count + 32'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_phase     <= 1'b0;
         r_count     <= REG_RST;
         r_compare   <= REG_RST;
         r_timer_int <= 1'b0;
      end else begin
         if (i_count_we) begin
            r_count <= i_wdata;
            r_phase <= 1'b0;
         end else begin
            r_phase <= w_tick ? 1'b0 : r_phase + 1'b1;
            if (w_tick)
               r_count <= w_count_inc;
         end

         if (i_compare_we)
            r_compare <= i_wdata;

         // A Compare write clears the interrupt even on a matching increment.
         if (i_compare_we)
            r_timer_int <= 1'b0;
         else if (!i_count_we && w_tick && (w_count_inc == r_compare))
            r_timer_int <= 1'b1;
      end
   end

   assign o_count     = r_count;
   assign o_compare   = r_compare;
   assign o_timer_int = r_timer_int;

endmodule

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: exception commit, mtc0/mfc0 access,
// interrupt synchronisation into Cause.IP and the Count/Compare timer.
module cp0_regfile
   import cp0_pkg::*;
#(
   parameter int unsigned COUNT_DIV  = 2,
   parameter logic [31:0] STATUS_RST = STATUS_RST_DEF
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        expwrite,
   input  logic [31:0] exp_epc,
   input  logic [31:0] exp_badvaddr,
   input  logic [31:0] exp_status,
   input  logic [31:0] exp_cause,
   input  logic        mtc0_we,
   input  logic [4:0]  mtc0_addr,
   input  logic [31:0] mtc0_wdata,
   input  logic [4:0]  mfc0_addr,
   output logic [31:0] mfc0_rdata,
   input  logic [5:0]  hw_int,
   output logic [31:0] epc,
   output logic [31:0] badvaddr,
   output logic [31:0] status,
   output logic [31:0] cause,
   output logic        timer_int
);

   logic [31:0] r_epc;
   logic [31:0] r_badvaddr;
   logic [31:0] r_status;
   logic        r_bd;
   logic [1:0]  r_ip_sw;
   logic [4:0]  r_exccode;
   logic [5:0]  r_ip_hw;
   logic [5:0]  r_sync1;
   logic [5:0]  r_sync2;

   logic        w_count_we;
   logic        w_compare_we;
   logic [31:0] w_count;
   logic [31:0] w_compare;
   logic        w_timer_int;
   logic [31:0] w_cause;
   logic        w_unused;

   assign w_count_we   = mtc0_we && (mtc0_addr == CP0_COUNT);
   assign w_compare_we = mtc0_we && (mtc0_addr == CP0_COMPARE);
   assign w_unused     = ^{exp_cause[30:10], exp_cause[7], exp_cause[1:0]};

   cp0_timer #(
      .COUNT_DIV (COUNT_DIV)
   ) u_timer (
      .clk          (clk),
      .rst          (rst),
      .i_count_we   (w_count_we),
      .i_compare_we (w_compare_we),
      .i_wdata      (mtc0_wdata),
      .o_count      (w_count),
      .o_compare    (w_compare),
      .o_timer_int  (w_timer_int)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_epc      <= REG_RST;
         r_badvaddr <= REG_RST;
         r_status   <= STATUS_RST;
         r_bd       <= 1'b0;
         r_ip_sw    <= '0;
         r_exccode  <= '0;
         r_ip_hw    <= '0;
         r_sync1    <= '0;
         r_sync2    <= '0;
      end else begin
         r_sync1 <= hw_int;
         r_sync2 <= r_sync1;
         r_ip_hw <= {r_sync2[5] | w_timer_int, r_sync2[4:0]};

         // Exception commit owns Status/Cause/EPC/BadVAddr for this cycle.
         if (expwrite) begin
            r_epc      <= exp_epc;
            r_badvaddr <= exp_badvaddr;
            r_status   <= status_merge(exp_status, STATUS_RST);
            r_bd       <= exp_cause[BD_BIT];
            r_ip_sw    <= exp_cause[IP_LSB +: 2];
            r_exccode  <= exp_cause[6:2];
         end else if (mtc0_we) begin
            case (mtc0_addr)
               CP0_STATUS: r_status <= status_merge(mtc0_wdata, STATUS_RST);
               CP0_CAUSE:  r_ip_sw  <= mtc0_wdata[IP_LSB +: 2];
               CP0_EPC:    r_epc    <= mtc0_wdata;
               default:    ;
            endcase
         end
      end
   end

   assign w_cause = {r_bd, w_timer_int, 14'b0, r_ip_hw, r_ip_sw, 1'b0, r_exccode, 2'b0};

   always_comb begin
      mfc0_rdata = '0;
      case (mfc0_addr)
         CP0_BADVADDR: mfc0_rdata = r_badvaddr;
         CP0_COUNT:    mfc0_rdata = w_count;
         CP0_COMPARE:  mfc0_rdata = w_compare;
         CP0_STATUS:   mfc0_rdata = r_status;
         CP0_CAUSE:    mfc0_rdata = w_cause;
         CP0_EPC:      mfc0_rdata = r_epc;
         default:      mfc0_rdata = '0;
      endcase
   end

   assign epc       = r_epc;
   assign badvaddr  = r_badvaddr;
   assign status    = r_status;
   assign cause     = w_cause;
   assign timer_int = w_timer_int;

endmodule
